// File: rtl/koa_sched_pkg.sv
// ---------------------------------------------------------------------------
// koa_sched_pkg
// Shared types and constants for the Karatsuba multiplier scheduler.
//   state_e  : scheduler FSM state (2-bit encoding)
//   id_t     : requester identifier (0 or 1)
//   LAT_MAX  : largest supported multiplier register latency
// ---------------------------------------------------------------------------
package koa_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef logic id_t;

  localparam int LAT_MAX = 4;

endpackage

// File: rtl/koa_rr_arb2.sv
// ---------------------------------------------------------------------------
// koa_rr_arb2
// Two-way round-robin grant, purely combinational.
//   valid0, valid1 : request valid from requester 0 / 1
//   en             : arbitration allowed this cycle (scheduler idle)
//   last_q         : id of the most recent grant
//   gnt            : one-hot grant vector (bit i grants requester i)
//   gnt_id         : id of the granted requester (0 when nothing is granted)
// ---------------------------------------------------------------------------
module koa_rr_arb2
  import koa_sched_pkg::*;
(
  input  logic       valid0,
  input  logic       valid1,
  input  logic       en,
  input  id_t        last_q,
  output logic [1:0] gnt,
  output id_t        gnt_id
);

  always_comb begin
    gnt    = '0;
    gnt_id = 1'b0;
    if (en && (valid0 || valid1)) begin
      // On a tie the requester that did not win last time goes first.
      if (valid0 && valid1) begin
        gnt_id = ~last_q;
      end else begin
        gnt_id = valid1;
      end
      gnt[gnt_id] = 1'b1;
    end
  end

endmodule

// File: rtl/koa_mult_sched.sv
// ---------------------------------------------------------------------------
// koa_mult_sched
// Schedules two operand sources onto one shared pipelined Karatsuba
// significand multiplier. One multiplication is in flight at a time: the
// granted operands are held on the multiplier inputs for LAT edges, the
// product is captured and returned with the owning requester id over a
// valid/ready response channel.
//
// Parameters
//   SW  : operand width; products are 2*SW bits
//   LAT : multiplier register latency in clock edges (1..LAT_MAX)
//
// Ports
//   clk, rst              : clock (rising edge), async active-low reset
//   reqN_valid_i          : requester N has operands
//   reqN_ready_o          : requester N accepted this cycle (combinational)
//   reqN_a_i, reqN_b_i    : requester N operands
//   mul_a_o, mul_b_o      : registered operands to the multiplier
//   mul_p_i               : multiplier product
//   rsp_valid_o           : product available
//   rsp_ready_i           : consumer takes the product
//   rsp_p_o, rsp_id_o     : registered product and its owner
//   busy_o                : high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module koa_mult_sched
  import koa_sched_pkg::*;
#(
  parameter int SW  = 24,
  parameter int LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid_i,
  output logic            req0_ready_o,
  input  logic [SW-1:0]   req0_a_i,
  input  logic [SW-1:0]   req0_b_i,
  input  logic            req1_valid_i,
  output logic            req1_ready_o,
  input  logic [SW-1:0]   req1_a_i,
  input  logic [SW-1:0]   req1_b_i,
  output logic [SW-1:0]   mul_a_o,
  output logic [SW-1:0]   mul_b_o,
  input  logic [2*SW-1:0] mul_p_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [2*SW-1:0] rsp_p_o,
  output logic            rsp_id_o,
  output logic            busy_o
);

  localparam int CW = $clog2(LAT + 1);

  state_e         state;
  id_t            last_q;
  id_t            id_q;
  logic [CW-1:0]  cnt;

  logic [SW-1:0]   op_a_p0;
  logic [SW-1:0]   op_b_p0;
  logic [2*SW-1:0] rsp_p_p1;
  id_t             rsp_id_p1;
  logic            vld_p1;
  logic            busy_q;

  logic            arb_en;
  logic [1:0]      gnt;
  id_t             gnt_id;
  logic [SW-1:0]   sel_a;
  logic [SW-1:0]   sel_b;

  // Arbitration is only open in IDLE; gating with rst keeps both readies
  // low for the whole time reset is asserted, not just after an edge.
  assign arb_en = (state == IDLE) && rst;

  koa_rr_arb2 u_arb (
    .valid0 (req0_valid_i),
    .valid1 (req1_valid_i),
    .en     (arb_en),
    .last_q (last_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req0_ready_o = gnt[0];
  assign req1_ready_o = gnt[1];

  assign sel_a = gnt_id ? req1_a_i : req0_a_i;
  assign sel_b = gnt_id ? req1_b_i : req0_b_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      cnt       <= '0;
      op_a_p0   <= '0;
      op_b_p0   <= '0;
      rsp_p_p1  <= '0;
      rsp_id_p1 <= 1'b0;
      vld_p1    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // stage p0: granted operands latched onto the multiplier inputs
          if (|gnt) begin
            op_a_p0 <= sel_a;
            op_b_p0 <= sel_b;
            id_q    <= gnt_id;
            last_q  <= gnt_id;
            cnt     <= CW'(LAT);
            busy_q  <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          // stage p1: product sampled once the multiplier has had LAT edges
          if (cnt == '0) begin
            rsp_p_p1  <= mul_p_i;
            rsp_id_p1 <= id_q;
            vld_p1    <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            vld_p1 <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          vld_p1 <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign mul_a_o     = op_a_p0;
  assign mul_b_o     = op_b_p0;
  assign rsp_p_o     = rsp_p_p1;
  assign rsp_id_o    = rsp_id_p1;
  assign rsp_valid_o = vld_p1;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_koa_mult_sched.sv
// ---------------------------------------------------------------------------
// tb_koa_mult_sched
// Bench for koa_mult_sched. Two instances: LAT=1 (main, directed + random
// traffic, checked by a transaction-level model) and LAT=3 (directed).
// A behavioural LAT-stage multiplier feeds each instance.
// ---------------------------------------------------------------------------
module tb_koa_mult_sched;

  localparam int SW   = 24;
  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  logic rst;

  // LAT=1 instance
  logic          v0, v1, r0, r1, rv, rr, rid, busy;
  logic [SW-1:0] a0, b0, a1, b1, ma, mb;
  logic [2*SW-1:0] mp, rp;
  logic [2*SW-1:0] pipe1 [LAT1];

  // LAT=3 instance
  logic          v0_3, v1_3, r0_3, r1_3, rv3, rr3, rid3, busy3;
  logic [SW-1:0] a0_3, b0_3, a1_3, b1_3, ma3, mb3;
  logic [2*SW-1:0] mp3, rp3;
  logic [2*SW-1:0] pipe3 [LAT3];

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;

  // transaction-level model state for the LAT=1 instance
  bit            m_out;
  bit            m_last;
  bit            m_id;
  logic [SW-1:0] m_a, m_b;
  logic [63:0]   m_p;
  int            m_acc;
  bit            hs0, hs1;
  bit            gnt_q [$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pipe1[0] <= {24'b0, ma} * {24'b0, mb};
    pipe3[0] <= {24'b0, ma3} * {24'b0, mb3};
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mp  = pipe1[LAT1-1];
  assign mp3 = pipe3[LAT3-1];

  koa_mult_sched #(.SW(SW), .LAT(LAT1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(v0), .req0_ready_o(r0), .req0_a_i(a0), .req0_b_i(b0),
    .req1_valid_i(v1), .req1_ready_o(r1), .req1_a_i(a1), .req1_b_i(b1),
    .mul_a_o(ma), .mul_b_o(mb), .mul_p_i(mp),
    .rsp_valid_o(rv), .rsp_ready_i(rr), .rsp_p_o(rp), .rsp_id_o(rid),
    .busy_o(busy)
  );

  koa_mult_sched #(.SW(SW), .LAT(LAT3)) dut3 (
    .clk(clk), .rst(rst),
    .req0_valid_i(v0_3), .req0_ready_o(r0_3), .req0_a_i(a0_3), .req0_b_i(b0_3),
    .req1_valid_i(v1_3), .req1_ready_o(r1_3), .req1_a_i(a1_3), .req1_b_i(b1_3),
    .mul_a_o(ma3), .mul_b_o(mb3), .mul_p_i(mp3),
    .rsp_valid_o(rv3), .rsp_ready_i(rr3), .rsp_p_o(rp3), .rsp_id_o(rid3),
    .busy_o(busy3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] prod(input logic [SW-1:0] a, input logic [SW-1:0] b);
    return {40'b0, a} * {40'b0, b};
  endfunction

  // Model of the LAT=1 instance, evaluated once per cycle at the falling edge.
  task automatic mon();
    bit w;
    bit any;
    if (!rst) begin
      chk("ready_in_reset", {r1, r0}, 0);
      m_out = 0; m_last = 1; m_a = '0; m_b = '0; hs0 = 0; hs1 = 0;
      return;
    end
    hs0 = v0 && r0;
    hs1 = v1 && r1;
    chk("mul_a", ma, m_a);
    chk("mul_b", mb, m_b);
    chk("busy", busy, m_out);
    if (!m_out) begin
      any = v0 || v1;
      w   = (v0 && v1) ? !m_last : v1;
      chk("ready_idle", {r1, r0}, any ? (w ? 2'b10 : 2'b01) : 2'b00);
      chk("rsp_valid_idle", rv, 0);
      if (any) begin
        m_out  = 1;
        m_id   = w;
        m_a    = w ? a1 : a0;
        m_b    = w ? b1 : b0;
        m_p    = prod(m_a, m_b);
        m_acc  = cyc;
        m_last = w;
        gnt_q.push_back(w);
      end
    end else begin
      chk("ready_busy", {r1, r0}, 0);
      chk("rsp_valid", rv, (cyc >= m_acc + LAT1 + 2));
      if (rv) begin
        chk("rsp_p", rp, m_p);
        chk("rsp_id", rid, m_id);
        if (rr) m_out = 0;
      end
    end
  endtask

  task automatic smp();
    @(negedge clk);
    mon();
  endtask

  task automatic adv();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin smp(); adv(); end
  endtask

  function automatic bit pick(input int sel);
    case (sel)
      0:       return r0;
      1:       return r1;
      2:       return rv;
      3:       return r0_3;
      default: return rv3;
    endcase
  endfunction

  // Leaves the bench at the falling edge of the cycle where the signal is high.
  task automatic wait_for(input int sel, input int max, input string tag);
    bit hit = 0;
    for (int k = 0; k < max; k++) begin
      smp();
      hit = pick(sel);
      if (hit) break;
      adv();
    end
    if (!hit) chk({tag, "_timeout"}, hit, 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    smp(); adv(); smp(); adv();
    rst = 1'b1;
  endtask

  initial begin
    int t_acc;
    int base;
    bit hit;
    logic [63:0] exp_p;

    rst = 1'b0;
    v0 = 0; v1 = 0; a0 = '0; b0 = '0; a1 = '0; b1 = '0; rr = 1;
    v0_3 = 0; v1_3 = 0; a0_3 = '0; b0_3 = '0; a1_3 = '0; b1_3 = '0; rr3 = 1;
    m_out = 0; m_last = 1; m_id = 0; m_a = '0; m_b = '0; m_p = '0; m_acc = 0;

    // reset state before any clock edge
    #2;
    chk("rst_mul_a", ma, 0);
    chk("rst_mul_b", mb, 0);
    chk("rst_rsp_p", rp, 0);
    chk("rst_rsp_valid", rv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_busy3", busy3, 0);
    @(posedge clk); #1;
    smp(); adv(); smp(); adv();
    rst = 1'b1;

    // single request, all-ones operands
    v0 = 1; a0 = 24'hFFFFFF; b0 = 24'hFFFFFF; rr = 1;
    wait_for(0, 10, "single_acc");
    t_acc = cyc;
    adv();
    v0 = 0;
    wait_for(2, 10, "single_rsp");
    chk("single_latency", cyc - t_acc, 3);
    chk("single_p", rp, 48'hFFFFFE000001);
    chk("single_id", rid, 0);
    adv();
    idle(2);

    // tie arbitration from reset
    do_reset();
    v0 = 1; v1 = 1; rr = 1;
    a0 = 24'h000011; b0 = 24'h000022; a1 = 24'h000033; b1 = 24'h000044;
    base = gnt_q.size();
    for (int k = 0; k < 40 && gnt_q.size() < base + 4; k++) begin
      smp(); adv();
      if (hs0) begin a0 = 24'($urandom); b0 = 24'($urandom); end
      if (hs1) begin a1 = 24'($urandom) | 24'h800000; b1 = 24'($urandom); end
    end
    v0 = 0; v1 = 0;
    chk("tie_grants", gnt_q.size() - base, 4);
    for (int i = 0; i < 4 && base + i < gnt_q.size(); i++)
      chk($sformatf("tie_grant%0d", i), gnt_q[base + i], i % 2);
    idle(6);

    // response backpressure with req1 waiting
    rr = 0; v0 = 1; a0 = 24'h123456; b0 = 24'h00ABCD;
    exp_p = prod(24'h123456, 24'h00ABCD);
    wait_for(0, 10, "bp_acc");
    adv();
    v0 = 0;
    wait_for(2, 10, "bp_rsp");
    adv();
    v1 = 1; a1 = 24'h0F0F0F; b1 = 24'h000003;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("bp_rsp_p", rp, exp_p);
      chk("bp_rsp_valid", rv, 1);
      chk("bp_ready", {r1, r0}, 0);
      adv();
    end
    rr = 1;
    smp(); adv();
    smp();
    chk("bp_next_accept", r1, 1);
    adv();
    v1 = 0;
    idle(6);

    // reset while an operation is in WAIT
    v0 = 1; a0 = 24'h00F00D; b0 = 24'h000BAD;
    wait_for(0, 10, "rw_acc");
    adv();
    v0 = 0;
    rst = 1'b0;
    #1;
    chk("rw_mul_a", ma, 0);
    chk("rw_mul_b", mb, 0);
    chk("rw_rsp_p", rp, 0);
    chk("rw_rsp_id", rid, 0);
    chk("rw_rsp_valid", rv, 0);
    chk("rw_busy", busy, 0);
    chk("rw_ready", {r1, r0}, 0);
    smp(); adv();
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      smp();
      chk("rw_no_rsp", rv, 0);
      adv();
    end
    v0 = 1; v1 = 1; a0 = 24'h000005; b0 = 24'h000007; a1 = 24'h000009; b1 = 24'h00000B;
    smp();
    chk("rw_tie_req0", {r1, r0}, 2'b01);
    adv();
    v0 = 0; v1 = 0;
    idle(6);

    // idle stability
    for (int k = 0; k < 20; k++) begin
      smp();
      chk("idle_busy", busy, 0);
      chk("idle_rsp_valid", rv, 0);
      chk("idle_mul_a", ma, 24'h000005);
      chk("idle_mul_b", mb, 24'h000007);
      adv();
    end

    // LAT=3 instance
    v0_3 = 1; a0_3 = 24'h800000; b0_3 = 24'h000002; rr3 = 1;
    wait_for(3, 10, "l3_acc");
    t_acc = cyc;
    adv();
    v0_3 = 0;
    hit = 0;
    for (int k = 0; k < 12; k++) begin
      smp();
      if (rv3) begin hit = 1; break; end
      chk("l3_mul_a", ma3, 24'h800000);
      chk("l3_mul_b", mb3, 24'h000002);
      adv();
    end
    chk("l3_rsp_seen", hit, 1);
    chk("l3_latency", cyc - t_acc, 5);
    chk("l3_p", rp3, 48'h000001000000);
    chk("l3_id", rid3, 0);
    adv();
    idle(3);

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      if (!v0 || hs0) begin
        v0 = ($urandom % 2) != 0;
        a0 = ($urandom % 8 == 0) ? 24'hFFFFFF : 24'($urandom);
        b0 = ($urandom % 8 == 0) ? 24'h000000 : 24'($urandom);
      end
      if (!v1 || hs1) begin
        v1 = ($urandom % 2) != 0;
        a1 = 24'($urandom);
        b1 = ($urandom % 8 == 0) ? 24'hFFFFFF : 24'($urandom);
      end
      rr = ($urandom % 4) != 0;
      smp(); adv();
    end
    v0 = 0; v1 = 0; rr = 1;
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
